// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

  localparam int unsigned DefMultCycles = 5;
  localparam int unsigned DefDivCycles  = 10;

  // True for ops that occupy the unit for multiple cycles.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: signed/unsigned product, quotient and
// remainder from the latched operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_zero
);

  logic        w_b_zero;
  logic [31:0] w_div_b;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;

  // Divisor forced to 1 on zero so the dividers never see x/0; result is discarded.
  assign w_b_zero = (i_b == 32'd0);
  assign w_div_b  = w_b_zero ? 32'd1 : i_b;

  assign w_a_neg = i_a[31];
  assign w_b_neg = w_div_b[31];
  assign w_abs_a = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_abs_b = w_b_neg ? (~w_div_b + 32'd1) : w_div_b;

  assign w_uq     = i_a / w_div_b;
  assign w_ur     = i_a % w_div_b;
  assign w_sq_mag = w_abs_a / w_abs_b;
  assign w_sr_mag = w_abs_a % w_abs_b;
  // 0x80000000 / -1 falls out naturally: magnitude 2^31, signs agree, quotient 0x80000000.
  assign w_sq     = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr     = w_a_neg ? (~w_sr_mag + 32'd1) : w_sr_mag;

  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  always_comb begin
    o_res_hi   = 32'd0;
    o_res_lo   = 32'd0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT: begin
        o_res_hi = w_sprod[63:32];
        o_res_lo = w_sprod[31:0];
      end
      MD_MULTU: begin
        o_res_hi = w_uprod[63:32];
        o_res_lo = w_uprod[31:0];
      end
      MD_DIV: begin
        o_res_hi   = w_sr;
        o_res_lo   = w_sq;
        o_div_zero = w_b_zero;
      end
      MD_DIVU: begin
        o_res_hi   = w_ur;
        o_res_lo   = w_uq;
        o_div_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: busy counter, operand latches, HI/LO ownership
// and the D-stage stall request.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_op, w_op_nxt;
  logic [31:0] r_a, w_a_nxt;
  logic [31:0] r_b, w_b_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  logic        w_start_ok;
  logic        w_start_eff;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;

  assign w_start_ok  = start & ~flush;
  assign w_start_eff = w_start_ok & is_md_op(op);

  mdu_arith u_arith (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      StIdle: begin
        if (w_start_eff) begin
          w_op_nxt    = op;
          w_a_nxt     = rs_val;
          w_b_nxt     = rt_val;
          w_cnt_nxt   = is_mul_op(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          w_state_nxt = StBusy;
        end else if (w_start_ok && op == MD_MTHI) begin
          w_hi_nxt = rs_val;
        end else if (w_start_ok && op == MD_MTLO) begin
          w_lo_nxt = rs_val;
        end
      end
      StBusy: begin
        // Starts arriving here are ignored; stall_req keeps the pipeline from issuing them.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = StIdle;
          if (!w_div_zero) begin
            w_hi_nxt = w_res_hi;
            w_lo_nxt = w_res_lo;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy      = (r_state == StBusy);
  assign stall_req = d_uses_md & (busy | w_start_eff);
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the E stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with operands from E, models fixed multi-cycle latency with a busy counter, owns the HI/LO registers, and raises a stall request so D holds any HI/LO-touching instruction while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- start  in  1  E-stage instruction is an MD op this cycle
- op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE
- flush  in  1  E instruction is cancelled (exception/interrupt); suppresses start this cycle
- rs_val  in  32  operand A (dividend, multiplicand, or MTHI/MTLO source)
- rt_val  in  32  operand B
- d_uses_md  in  1  D-stage instruction reads or writes HI/LO, or is an MD op
- busy  out  1  multi-cycle operation in flight
- stall_req  out  1  d_uses_md & (busy | start_eff), where start_eff = start & ~flush & (op is MULT/MULTU/DIV/DIVU)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Counter cnt (4 bits); latched operands a_q, b_q and op_q.
- IDLE, start_eff: latch rs_val/rt_val/op, cnt <= MULT_CYCLES or DIV_CYCLES, go BUSY.
- IDLE, start & ~flush & op=MTHI: hi <= rs_val; op=MTLO: lo <= rs_val. No busy; stays IDLE.
- BUSY: cnt decrements each cycle; when cnt==1, write the result at that edge and go IDLE.
- MULT: {hi,lo} <= signed 32x32 to 64 product; MULTU: unsigned product.
- DIV: lo <= signed quotient (truncated toward zero), hi <= remainder with the sign of the dividend; DIVU: unsigned quotient/remainder.
- Divide by zero: hi and lo remain unchanged; busy still lasts DIV_CYCLES.
- 0x80000000 / -1 (DIV): lo <= 0x80000000, hi <= 0.
- Any start while BUSY is ignored. The pipeline cannot produce this case because of stall_req; the bench flags it with an assertion.
- flush affects only the same-cycle start. An operation already in BUSY runs to completion.
- op NONE/7 with start: no effect.

## Timing
- Reset values: state IDLE, cnt 0, busy 0, stall_req 0 (given d_uses_md=0), hi 0x0, lo 0x0.
- start_eff sampled at edge T0: busy is high in cycles T0+1 .. T0+N, where N is the op latency. hi/lo take the result at the end of cycle T0+N and are visible from T0+N+1, when busy is 0.
- MTHI/MTLO sampled at edge T0: the new value is visible from T0+1.
- stall_req is combinational and asserts in the start cycle itself, so a D-stage MFHI directly behind a MULT stalls.
- The back-to-back op is accepted in the first cycle busy is 0.
- Reset asserted mid-BUSY: the operation is abandoned, hi=lo=0, IDLE at once. After reset deasserts, the first edge may accept start.

## Structure
- Shared package mdu_pkg: op encodings (MD_NONE..MD_MTLO), state encoding, and default latency constants.
- Sub-module mdu_arith: purely combinational. Inputs op_q, a_q, b_q; outputs {res_hi, res_lo, div_zero}. It isolates the signed/unsigned product, quotient, remainder and corner-case logic.
- mdu_ctrl holds the FSM, counter, operand latches, HI/LO and stall logic.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles. Back-to-back DIVU 7/2 on the first non-busy cycle → after 10 cycles lo=3, hi=1.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV by 0 with hi=0x11, lo=0x22 preset via MTHI/MTLO → unchanged after 10 busy cycles.
- start=1 op=MULT with flush=1 → busy stays 0, hi/lo unchanged, stall_req follows d_uses_md & 0. A later flush pulse mid-DIV → operation still completes.
- d_uses_md=1 held through MULT → stall_req high in the start cycle and all 5 busy cycles, low in the cycle hi/lo become valid.
- reset pulled low in busy cycle 3 of DIV → busy=0, hi=lo=0 immediately. After release, MTLO 0xABCD → lo=0xABCD next cycle.
